// File: rtl/lifo_stack_pkg.sv
// Shared operation encoding for the LIFO stack.
// The encoding is {push, pop}, so the raw request pins map straight onto it.
package lifo_stack_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  function automatic op_e op_decode(input logic push, input logic pop);
    return op_e'({push, pop});
  endfunction

endpackage

// File: rtl/lifo_stack_ram.sv
// Deep storage for stack elements 2..DEPTH-1.
// One synchronous write port at ptr, one combinational read port at ptr-1.
module lifo_stack_ram
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_ptr,
  input  logic [WIDTH-1:0]         i_wr_data,
  output logic [WIDTH-1:0]         o_rd_data
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRIES = DEPTH - 2;
  localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [PTR_W-1:0] rd_ptr;

  assign rd_ptr = i_ptr - PTR_W'(1);

  // An empty deep store makes rd_ptr wrap past the last entry; return 0 there.
  assign o_rd_data = (rd_ptr < PTR_W'(ENTRIES)) ? mem_q[IDX_W'(rd_ptr)] : '0;

  always_ff @(posedge i_clk) begin
    if (i_we && (i_ptr < PTR_W'(ENTRIES))) begin
      mem_q[IDX_W'(i_ptr)] <= i_wr_data;
    end
  end

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack: top two elements in registers, the rest in a small RAM.
// One operation per cycle, results visible one cycle after the request edge.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clr,
  output logic [WIDTH-1:0]           o_s0,
  output logic [WIDTH-1:0]           o_s1,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_err
);

  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] s0_q, s0_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PTR_W-1:0] dptr_q, dptr_d;
  logic             err_q, err_d;
  logic             ram_we;
  logic [WIDTH-1:0] ram_rd_data;
  op_e              op;

  assign op = op_decode(i_push, i_pop);

  always_comb begin
    s0_d    = s0_q;
    s1_d    = s1_q;
    count_d = count_q;
    dptr_d  = dptr_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    if (i_clr) begin
      s0_d    = '0;
      s1_d    = '0;
      count_d = '0;
      dptr_d  = '0;
      err_d   = 1'b0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (count_q == CW'(DEPTH)) begin
            err_d = 1'b1;
          end else begin
            s0_d    = i_data;
            s1_d    = s0_q;
            count_d = count_q + CW'(1);
            // Old s1 moves into deep storage once both registers are occupied.
            if (count_q >= CW'(2)) begin
              ram_we = 1'b1;
              dptr_d = dptr_q + PTR_W'(1);
            end
          end
        end
        OP_POP: begin
          if (count_q == '0) begin
            err_d = 1'b1;
          end else begin
            s0_d    = s1_q;
            count_d = count_q - CW'(1);
            if (count_q >= CW'(3)) begin
              s1_d   = ram_rd_data;
              dptr_d = dptr_q - PTR_W'(1);
            end else begin
              s1_d = '0;
            end
          end
        end
        OP_REPLACE: begin
          if (count_q == '0) begin
            err_d = 1'b1;
          end else begin
            s0_d = i_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s0_q    <= '0;
      s1_q    <= '0;
      count_q <= '0;
      dptr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      count_q <= count_d;
      dptr_q  <= dptr_d;
      err_q   <= err_d;
    end
  end

  lifo_stack_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .i_clk    (i_clk),
    .i_we     (ram_we),
    .i_ptr    (dptr_q),
    .i_wr_data(s1_q),
    .o_rd_data(ram_rd_data)
  );

  assign o_s0    = s0_q;
  assign o_s1    = s1_q;
  assign o_count = count_q;
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_err   = err_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard bench for lifo_stack (WIDTH=8, DEPTH=4) against a queue-based stack model.
// Stimulus pushes expected post-edge state; a monitor compares after each rising edge.
module tb_lifo_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic [CW-1:0]    cnt;
    logic             emp;
    logic             ful;
    logic             err;
    string            tag;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] data;
  logic             push, pop, clr;
  logic [WIDTH-1:0] s0, s1;
  logic [CW-1:0]    count;
  logic             empty, full, err;

  int total = 0;
  int bad   = 0;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] stk[$];
  logic             m_err = 1'b0;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_data (data),
    .i_push (push),
    .i_pop  (pop),
    .i_clr  (clr),
    .o_s0   (s0),
    .o_s1   (s1),
    .o_count(count),
    .o_empty(empty),
    .o_full (full),
    .o_err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model_view(input string tag);
    exp_t e;
    int n;
    n     = stk.size();
    e.s0  = (n > 0) ? stk[n-1] : '0;
    e.s1  = (n > 1) ? stk[n-2] : '0;
    e.cnt = CW'(n);
    e.emp = (n == 0);
    e.ful = (n == DEPTH);
    e.err = m_err;
    e.tag = tag;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    total++;
    if (s0 !== e.s0 || s1 !== e.s1 || count !== e.cnt ||
        empty !== e.emp || full !== e.ful || err !== e.err) begin
      bad++;
      $display("FAIL %s: got s0=%h s1=%h cnt=%0d emp=%b ful=%b err=%b, want s0=%h s1=%h cnt=%0d emp=%b ful=%b err=%b",
               e.tag, s0, s1, count, empty, full, err,
               e.s0, e.s1, e.cnt, e.emp, e.ful, e.err);
    end else begin
      $display("ok   %s: s0=%h s1=%h cnt=%0d err=%b", e.tag, s0, s1, count, err);
    end
  endtask

  // Drive one operation at the falling edge and record what the stack should look like after it.
  task automatic do_op(input logic p, input logic q, input logic c,
                       input logic [WIDTH-1:0] d, input string tag);
    @(negedge clk);
    push = p; pop = q; clr = c; data = d;
    if (c) begin
      stk.delete();
      m_err = 1'b0;
    end else if (p && q) begin
      if (stk.size() == 0) m_err = 1'b1;
      else stk[stk.size()-1] = d;
    end else if (p) begin
      if (stk.size() == DEPTH) m_err = 1'b1;
      else stk.push_back(d);
    end else if (q) begin
      if (stk.size() == 0) m_err = 1'b1;
      else void'(stk.pop_back());
    end
    exp_q.push_back(model_view(tag));
  endtask

  task automatic idle();
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr = 1'b0; data = '0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare(e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [WIDTH-1:0] seq[4];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0; data = '0;
    #12;
    compare(model_view("reset_state"));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) do_op(1, 0, 0, seq[i], $sformatf("fill_push_%0d", i));
    do_op(1, 0, 0, 8'h55, "overflow_push");
    for (int i = 0; i < 4; i++) do_op(0, 1, 0, 8'h00, $sformatf("drain_pop_%0d", i));
    do_op(0, 1, 0, 8'h00, "underflow_pop");
    do_op(0, 0, 0, 8'h00, "err_sticky_nop");
    do_op(0, 0, 1, 8'h00, "clear");

    do_op(1, 0, 0, 8'h11, "pp_push_11");
    do_op(1, 0, 0, 8'h22, "pp_push_22");
    do_op(1, 1, 0, 8'h99, "replace_99");
    do_op(0, 1, 0, 8'h00, "pp_pop_a");
    do_op(0, 1, 0, 8'h00, "pp_pop_b");
    do_op(1, 1, 0, 8'h77, "replace_empty");
    do_op(1, 0, 1, 8'h66, "clear_over_push");

    do_op(1, 0, 0, 8'hA1, "alt_pre_a");
    do_op(1, 0, 0, 8'hA2, "alt_pre_b");
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) do_op(1, 0, 0, WIDTH'($urandom), $sformatf("alt_push_%0d", i));
      else            do_op(0, 1, 0, 8'h00, $sformatf("alt_pop_%0d", i));
    end

    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3)       do_op(0, 0, 1, WIDTH'($urandom), $sformatf("rnd_%0d_clr", i));
      else if (r < 40) do_op(1, 0, 0, WIDTH'($urandom), $sformatf("rnd_%0d_push", i));
      else if (r < 75) do_op(0, 1, 0, WIDTH'($urandom), $sformatf("rnd_%0d_pop", i));
      else if (r < 88) do_op(1, 1, 0, WIDTH'($urandom), $sformatf("rnd_%0d_repl", i));
      else             do_op(0, 0, 0, WIDTH'($urandom), $sformatf("rnd_%0d_nop", i));
    end

    do_op(0, 0, 1, 8'h00, "pre_rst_clear");
    do_op(1, 0, 0, 8'hC1, "pre_rst_push_a");
    do_op(1, 0, 0, 8'hC2, "pre_rst_push_b");
    do_op(1, 0, 0, 8'hC3, "pre_rst_push_c");
    @(posedge clk);
    #3;
    push = 1'b0; pop = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    stk.delete();
    m_err = 1'b0;
    #1;
    compare(model_view("async_reset_mid_cycle"));
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1, 0, 0, 8'hD1, "post_rst_push");
    do_op(0, 1, 0, 8'h00, "post_rst_pop");
    idle();
    @(posedge clk);
    #2;

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
